plru_set_tracker: RTL
=====================

# plru_set_tracker

Sequential tree pseudo-LRU replacement tracker for a set-associative cache. It stores per-set PLRU tree bits and per-way valid bits, and serves victim-query, hit-touch, allocate and invalidate requests over a valid/ready handshake. It sits beside the tag array in the cache controller. It generalises the combinational 8-way victim selector to parametrised associativity and set count, adds state update and invalid-way preference.

## Interface
- ASSOC, 8, ways per set; power of two, >= 2
- SETS, 16, number of sets; power of two, >= 2
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  tracker can accept a request
- req_op  input  2  00 VICTIM, 01 TOUCH, 10 ALLOC, 11 INVAL
- req_set  input  $clog2(SETS)  target set
- req_way  input  $clog2(ASSOC)  target way (TOUCH, INVAL; ignored otherwise)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_way  output  $clog2(ASSOC)  selected/affected way
- rsp_from_invalid  output  1  rsp_way was chosen because it was invalid
- rsp_err  output  1  TOUCH addressed an invalid way

## Operation
- Tree: ASSOC-1 bits per set, node 0 root, children of node a are 2a+1 (left, lower ways) and 2a+2 (right).
- Victim walk: bit 0 -> go right, bit 1 -> go left; each step contributes one way bit, MSB first (right = 1).
- Touch of way w: every node on w's path is set to 1 if w's path goes right there, 0 if left (points the victim away from w). Off-path nodes unchanged.
- Victim choice: if any way in the set is invalid, the lowest-index invalid way, with rsp_from_invalid=1. Otherwise the tree walk, with rsp_from_invalid=0.
- VICTIM: return victim choice; no state change.
- TOUCH: if req_way is valid, touch it, rsp_way=req_way, rsp_err=0. If invalid, no state change, rsp_err=1.
- ALLOC: compute victim choice, set its valid bit, touch it, return it.
- INVAL: clear the valid bit of req_way; PLRU bits unchanged; rsp_way=req_way.
- Only one request is outstanding; sets are fully independent.
- FSM states:
  - IDLE (req_ready=1): a handshake moves to CALC and registers op/set/way plus the set's tree and valid bits.
  - CALC: computes the result; on its exit edge, writes the state back and loads the response registers; moves to RESP.
  - RESP (rsp_valid=1): on rsp_valid && rsp_ready, returns to IDLE.

## Timing
- Reset: req_ready=1, rsp_valid=0, rsp_way=0, rsp_from_invalid=0, rsp_err=0; all tree bits 0, all valid bits 0; FSM IDLE.
- Accept at edge T. Response registers are loaded and rsp_valid rises at edge T+2. State write commits at edge T+2.
- A request accepted after the response sees the updated state; there is no forwarding hazard.
- Minimum request-to-request spacing is 3 cycles.
- req_ready is low in CALC and RESP. req_* inputs are ignored outside IDLE.
- While rsp_ready=0, the rsp_* outputs stay stable.
- Async reset in any state clears everything immediately: rsp_valid drops and the in-flight request is discarded with no state write.

## Configuration
- PLRU_INVALID_FIRST_EN defined: invalid-way preference as described above.
- Not defined: victim choice is always the tree walk and rsp_from_invalid is tied 0. Valid bits are still kept for TOUCH rsp_err and are still set by ALLOC.

## Test plan
- Reset, then VICTIM set 3 -> rsp_way=0, rsp_from_invalid=1 (macro off: rsp_way=7, from_invalid=0); rsp_valid rises 2 cycles after accept.
- Eight ALLOCs to set 5 -> ways 0..7 in order, each from_invalid=1. Ninth ALLOC -> rsp_way=0, from_invalid=0.
- Then TOUCH set 5 way 0, then VICTIM set 5 -> rsp_way=4; VICTIM set 6 -> rsp_way=0, from_invalid=1 (set isolation).
- INVAL set 5 way 2, then ALLOC set 5 -> rsp_way=2, from_invalid=1. Then TOUCH set 9 way 1 (invalid) -> rsp_err=1, and a following VICTIM set 9 still gives 0.
- Hold rsp_ready=0 for 3 cycles in RESP -> rsp_* stable, req_ready=0, a req_valid pulse is not accepted.
- Assert rst_n low during CALC of an ALLOC -> rsp_valid=0 at once, and after reset a VICTIM on the same set -> way 0, from_invalid=1.

Source files
------------

// File: rtl/plru_set_tracker_if.sv
// Request/response handshake bundle for the tree-PLRU set tracker.
// master drives requests and rsp_ready; slave is the tracker.
interface plru_set_tracker_if #(
   parameter int ASSOC = 8,
   parameter int SETS  = 16
);
   localparam int WW = $clog2(ASSOC);
   localparam int SW = $clog2(SETS);

   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [SW-1:0] req_set;
   logic [WW-1:0] req_way;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [WW-1:0] rsp_way;
   logic          rsp_from_invalid;
   logic          rsp_err;

   modport master (
      output req_valid,
      output req_op,
      output req_set,
      output req_way,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_way,
      input  rsp_from_invalid,
      input  rsp_err
   );

   modport slave (
      input  req_valid,
      input  req_op,
      input  req_set,
      input  req_way,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_way,
      output rsp_from_invalid,
      output rsp_err
   );
endinterface

// File: rtl/plru_set_tracker.sv
// Per-set tree pseudo-LRU and valid tracker with VICTIM/TOUCH/ALLOC/INVAL ops.
// Define PLRU_INVALID_FIRST_EN to prefer the lowest invalid way as victim.
module plru_set_tracker #(
   parameter int ASSOC = 8,
   parameter int SETS  = 16
) (
   input logic               clk,
   input logic               rst_n,
   plru_set_tracker_if.slave bus
);
   localparam int WW = $clog2(ASSOC);
   localparam int SW = $clog2(SETS);
   localparam int TW = ASSOC - 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      RESP
   } state_e;

   typedef enum logic [1:0] {
      OP_VICTIM = 2'b00,
      OP_TOUCH  = 2'b01,
      OP_ALLOC  = 2'b10,
      OP_INVAL  = 2'b11
   } op_e;

   typedef struct packed {
      logic [TW-1:0]    tree;
      logic [ASSOC-1:0] vld;
      logic [WW-1:0]    way;
      logic             from_inv;
      logic             err;
   } res_t;

   state_e state_q;
   state_e state_n;
   logic   phase_q;

   op_e           op_q;
   logic [SW-1:0] set_q;
   logic [WW-1:0] way_q;
   logic [TW-1:0] tree_r;
   logic [ASSOC-1:0] vld_r;

   logic [SETS-1:0][TW-1:0]    tree_mem;
   logic [SETS-1:0][ASSOC-1:0] vld_mem;

   res_t res_n;
   res_t res_q;

   logic [WW-1:0] rsp_way_q;
   logic          rsp_fi_q;
   logic          rsp_err_q;

   logic [WW-1:0] victim;
   logic          vic_inv;
   logic          accept;

   // Bit 0 steers right, bit 1 steers left; right contributes a 1.
   function automatic logic [WW-1:0] walk(input logic [TW-1:0] t);
      logic [WW-1:0] w;
      int            n;
      w = '0;
      n = 0;
      for (int l = 0; l < WW; l++) begin
         w[WW-1-l] = ~t[n];
         n = 2*n + (w[WW-1-l] ? 2 : 1);
      end
      return w;
   endfunction

   function automatic logic [TW-1:0] touch(
      input logic [TW-1:0] t,
      input logic [WW-1:0] w
   );
      logic [TW-1:0] r;
      int            n;
      r = t;
      n = 0;
      for (int l = 0; l < WW; l++) begin
         r[n] = w[WW-1-l];
         n = 2*n + (w[WW-1-l] ? 2 : 1);
      end
      return r;
   endfunction

   function automatic logic [WW-1:0] first_inv(
      input logic [ASSOC-1:0] v
   );
      logic [WW-1:0] w;
      w = '0;
      for (int i = ASSOC-1; i >= 0; i--) begin
         if (!v[i]) w = WW'(i);
      end
      return w;
   endfunction

   assign accept = bus.req_valid && (state_q == IDLE);

   always_comb begin
      victim  = walk(tree_r);
      vic_inv = 1'b0;
`ifdef PLRU_INVALID_FIRST_EN
      if (!(&vld_r)) begin
         victim  = first_inv(vld_r);
         vic_inv = 1'b1;
      end
`endif
   end

   always_comb begin
      res_n.tree     = tree_r;
      res_n.vld      = vld_r;
      res_n.way      = way_q;
      res_n.from_inv = 1'b0;
      res_n.err      = 1'b0;
      unique case (op_q)
         OP_VICTIM: begin
            res_n.way      = victim;
            res_n.from_inv = vic_inv;
         end
         OP_TOUCH: begin
            if (vld_r[way_q]) res_n.tree = touch(tree_r, way_q);
            else              res_n.err  = 1'b1;
         end
         OP_ALLOC: begin
            res_n.way         = victim;
            res_n.from_inv    = vic_inv;
            res_n.vld[victim] = 1'b1;
            res_n.tree        = touch(tree_r, victim);
         end
         OP_INVAL: begin
            res_n.vld[way_q] = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_n;
   end

   always_comb begin
      state_n = state_q;
      unique case (state_q)
         IDLE:    if (bus.req_valid) state_n = CALC;
         CALC:    if (phase_q)       state_n = RESP;
         RESP:    if (bus.rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // CALC spans two cycles: result is pipelined, then committed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q   <= 1'b0;
         op_q      <= OP_VICTIM;
         set_q     <= '0;
         way_q     <= '0;
         tree_r    <= '0;
         vld_r     <= '0;
         res_q     <= '0;
         tree_mem  <= '0;
         vld_mem   <= '0;
         rsp_way_q <= '0;
         rsp_fi_q  <= 1'b0;
         rsp_err_q <= 1'b0;
      end else begin
         phase_q <= (state_q == CALC) && !phase_q;
         if (accept) begin
            op_q   <= op_e'(bus.req_op);
            set_q  <= bus.req_set;
            way_q  <= bus.req_way;
            tree_r <= tree_mem[bus.req_set];
            vld_r  <= vld_mem[bus.req_set];
         end
         if (state_q == CALC && !phase_q) begin
            res_q <= res_n;
         end
         if (state_q == CALC && phase_q) begin
            tree_mem[set_q] <= res_q.tree;
            vld_mem[set_q]  <= res_q.vld;
            rsp_way_q       <= res_q.way;
            rsp_fi_q        <= res_q.from_inv;
            rsp_err_q       <= res_q.err;
         end
      end
   end

   assign bus.req_ready        = (state_q == IDLE);
   assign bus.rsp_valid        = (state_q == RESP);
   assign bus.rsp_way          = rsp_way_q;
   assign bus.rsp_from_invalid = rsp_fi_q;
   assign bus.rsp_err          = rsp_err_q;
endmodule
